// File: rtl/sr_cmd_driver.sv
// Initiator for an S/R flop: turns level commands into legal one-cycle set/reset
// pulses, checks q_fb, then holds idle. Optional macro SR_HOLD_CHECK_EN also checks in HOLD.
module sr_cmd_driver #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_level,
    input  logic [LEN_W-1:0] cmd_hold,
    output logic             s,
    output logic             r,
    input  logic             q_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, HOLD} state_t;

    state_t           state, state_nxt;
    logic             exp_lvl;
    logic [LEN_W-1:0] hcnt;
    logic             accept;
    logic             mismatch;

    // Case inequality so an X/Z on q_fb is reported as a mismatch.
    assign mismatch = (q_fb !== exp_lvl);

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: state_nxt = CHECK;
            CHECK: begin
                err = mismatch;
                if (hcnt == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
`ifdef SR_HOLD_CHECK_EN
                err = mismatch;
`else
                err = 1'b0;
`endif
                if (hcnt == LEN_W'(1)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // s/r are loaded on the accepting edge so the pulse lands exactly in DRIVE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s       <= 1'b0;
            r       <= 1'b0;
            exp_lvl <= 1'b0;
            hcnt    <= '0;
            err_cnt <= '0;
        end else begin
            state <= state_nxt;
            s     <= accept & cmd_level;
            r     <= accept & ~cmd_level;
            if (accept) begin
                exp_lvl <= cmd_level;
                hcnt    <= cmd_hold;
            end else if (state == HOLD) begin
                hcnt <= hcnt - LEN_W'(1);
            end
            if (err && (err_cnt != '1))
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/sr_cmd_driver.md
Name: sr_cmd_driver

Overview:
- Initiator side of the S/R flip-flop interface.
- Accepts level commands over a valid/ready handshake and converts each one into a legal one-cycle set or reset pulse on s/r.
- Checks the flop's q output, fed back on q_fb, against the commanded level, then holds s=r=0 for a programmable number of cycles.
- Sits between a control sequencer and any srff-style storage element. Guarantees the invalid s=r=1 encoding is never driven.

Parameters:
LEN_W, 8, width of the hold-length field cmd_hold
CNT_W, 8, width of the saturating error counter err_cnt

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command; equals (state==IDLE)
cmd_level  input  1  target level: 1=set, 0=reset
cmd_hold  input  LEN_W  idle cycles to hold after the check, 0..2^LEN_W-1
s  output  1  set request to the flop (registered)
r  output  1  reset request to the flop (registered)
q_fb  input  1  q of the driven flop
busy  output  1  state!=IDLE
done  output  1  one-cycle pulse in the final cycle of a command
err  output  1  one-cycle pulse on any q_fb mismatch
err_cnt  output  CNT_W  saturating count of mismatches since reset

Behaviour:
- Reset, sampled only on posedge clk with rst=1:
  - state=IDLE.
  - s=0, r=0, done=0, err=0, err_cnt=0.
  - Latched level and hold counter cleared.
  - Reset mid-command aborts the command immediately. No done is issued for it. s and r are 0 from the next cycle.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge T: latch cmd_level into exp and cmd_hold into hcnt, go to DRIVE.
  - Inputs are ignored while cmd_ready=0.
- DRIVE (cycle T+1):
  - s=exp, r=~exp for exactly one cycle.
  - The flop captures the request at the end of T+1. Next state is CHECK.
- CHECK (cycle T+2):
  - s=r=0.
  - Mismatch is defined as q_fb !== exp, so X/Z on q_fb counts as a mismatch.
  - On mismatch: err=1, err_cnt increments (saturates at all-ones).
  - If hcnt==0: done=1 and next state is IDLE, so cmd_ready=1 at T+3.
  - Otherwise next state is HOLD.
- HOLD:
  - s=r=0.
  - hcnt decrements each cycle.
  - Per-cycle checking is controlled by the optional feature below.
  - When hcnt==1: done=1 and next state is IDLE.
  - Total occupancy is 2+cmd_hold busy cycles. Back-to-back commands therefore start every 3+cmd_hold cycles.
- Errors never stall or abort the sequence. The command completes normally and done still pulses.
- A command equal to the current q still produces the pulse; the flop simply stays put.
- Invariant at every cycle: !(s&r). s and r are both 0 outside DRIVE.
- err and done are registered-free combinational decodes of state plus q_fb. s and r come straight from flops.

Optional Feature:
- Macro: SR_HOLD_CHECK_EN.
- Defined: in every HOLD cycle q_fb is compared to exp. Each mismatching cycle pulses err and increments err_cnt, so a glitch lasting 3 cycles counts 3.
- Undefined: only the CHECK cycle is compared, and err is never asserted in HOLD.
- Ports and timing are identical in both builds.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then cmd_valid=0 -> s=r=0, cmd_ready=1, busy=0, err_cnt=0.
- Set with hold 0: cmd_level=1, cmd_hold=0 accepted at T, model flop q follows -> s=1,r=0 at T+1; done=1,err=0 at T+2; cmd_ready=1 at T+3.
- Reset with hold 4: q initially 1, cmd_level=0, cmd_hold=4 -> r=1 at T+1 only; done at T+6; err_cnt stays 0; s&r never 1 over the run.
- Stuck flop: q_fb forced 0, cmd_level=1, cmd_hold=2 -> err at T+2. With SR_HOLD_CHECK_EN, also at T+3 and T+4, giving err_cnt=3; without it, err_cnt=1. done at T+4 in both builds.
- Reset mid-HOLD: cmd_hold=10, rst=1 at T+5 -> next cycle state=IDLE, done never pulses, err_cnt=0, a new command is accepted right after.
- Saturation: with CNT_W=2, issue 5 commands against stuck q_fb -> err_cnt stops at 3.
